// File: rtl/ps2_mouse_init_sequencer_pkg.sv
// Shared PS/2 mouse protocol constants, sequencer state type and error codes.
package ps2_cmd_pkg;

    // Host-to-mouse command bytes
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // Mouse-to-host reply bytes
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ERROR    = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] MOUSE_ID     = 8'h00;

    // Index of the last entry in the init step table
    localparam logic [1:0] LAST_STEP    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_DONE,
        ST_FAIL
    } seq_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_TIMEOUT = 3'd1,
        ERR_REPLY   = 3'd2,
        ERR_BAT     = 3'd3
    } err_code_t;

endpackage

// File: rtl/ps2_mouse_init_sequencer_reply_timer.sv
// Loadable down-counter used to bound every wait for a mouse reply.
// The count parks at zero; o_expired stays high until the next load.
module ps2_reply_timer #(
    parameter int WIDTH = 25
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    // Load has priority; otherwise count down while enabled and not yet at zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/ps2_mouse_init_sequencer.sv
// Host-side PS/2 mouse bring-up: sends FF, F3, rate, F4, checks each reply,
// retries the whole sequence on faults and re-runs it on hot-plug (AA 00).
module ps2_mouse_init_sequencer
    import ps2_cmd_pkg::*;
#(
    parameter int         ACK_TIMEOUT = 2_500_000,
    parameter int         BAT_TIMEOUT = 25_000_000,
    parameter int         MAX_RETRIES = 3,
    parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
    input  logic       i_clock_50,
    input  logic       i_reset,
    input  logic       i_start,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    output logic       o_busy,
    output logic       o_ready,
    output logic       o_error,
    output logic [2:0] o_err_code,
    output logic [2:0] o_attempts
);

    localparam int TW = $clog2(BAT_TIMEOUT + 1);

    seq_state_t r_state, w_state_next;
    logic [1:0] r_idx, w_idx_next;
    logic [2:0] r_attempts, w_attempts_next;
    logic [2:0] r_err_code, w_err_code_next;
    logic       r_bat_seen, w_bat_seen_next;
    logic       r_hp_seen, w_hp_seen_next;
    logic       r_tx_valid;
    logic [7:0] r_tx_byte;
    logic       r_busy, r_ready, r_error;

    logic          w_timer_load;
    logic [TW-1:0] w_timer_value;
    logic          w_timer_en;
    logic          w_expired;
    logic          w_restart;
    logic          w_fault;
    err_code_t     w_fault_code;

    // Step table ROM: command byte issued at each index
    function automatic logic [7:0] step_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    step_cmd = CMD_RESET;
            2'd1:    step_cmd = CMD_SET_RATE;
            2'd2:    step_cmd = SAMPLE_RATE;
            default: step_cmd = CMD_ENABLE;
        endcase
    endfunction

    assign w_timer_en = (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_BAT);

    ps2_reply_timer #(
        .WIDTH(TW)
    ) u_timer (
        .i_clk       (i_clock_50),
        .i_rst       (i_reset),
        .i_load      (w_timer_load),
        .i_load_value(w_timer_value),
        .i_enable    (w_timer_en),
        .o_expired   (w_expired)
    );

    // State and sequencing registers
    always_ff @(posedge i_clock_50 or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_attempts <= 3'd0;
            r_err_code <= ERR_NONE;
            r_bat_seen <= 1'b0;
            r_hp_seen  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_attempts <= w_attempts_next;
            r_err_code <= w_err_code_next;
            r_bat_seen <= w_bat_seen_next;
            r_hp_seen  <= w_hp_seen_next;
        end
    end

    // Next-state logic: reply checking, timeouts, retries and restarts
    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_attempts_next = r_attempts;
        w_err_code_next = r_err_code;
        w_bat_seen_next = r_bat_seen;
        w_hp_seen_next  = r_hp_seen;
        w_timer_load    = 1'b0;
        w_timer_value   = TW'(ACK_TIMEOUT);
        w_restart       = 1'b0;
        w_fault         = 1'b0;
        w_fault_code    = ERR_NONE;

        case (r_state)
            ST_IDLE, ST_FAIL: begin
                if (i_start) begin
                    w_restart = 1'b1;
                end
            end
            ST_SEND: begin
                if (r_tx_valid && i_tx_ready) begin
                    w_state_next = ST_WAIT_ACK;
                    w_timer_load = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                // A reply arriving on the expiry cycle wins over the timeout
                if (i_rx_valid) begin
                    if (i_rx_byte == RSP_ACK) begin
                        if (r_idx == 2'd0) begin
                            w_state_next    = ST_WAIT_BAT;
                            w_bat_seen_next = 1'b0;
                            w_timer_load    = 1'b1;
                            w_timer_value   = TW'(BAT_TIMEOUT);
                        end else if (r_idx == LAST_STEP) begin
                            w_state_next   = ST_DONE;
                            w_hp_seen_next = 1'b0;
                        end else begin
                            w_idx_next   = r_idx + 2'd1;
                            w_state_next = ST_SEND;
                        end
                    end else if (i_rx_byte == RSP_RESEND) begin
                        w_state_next = ST_SEND;
                    end else begin
                        w_fault      = 1'b1;
                        w_fault_code = ERR_REPLY;
                    end
                end else if (w_expired) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_TIMEOUT;
                end
            end
            ST_WAIT_BAT: begin
                if (i_rx_valid) begin
                    if (!r_bat_seen && (i_rx_byte == RSP_BAT_OK)) begin
                        w_bat_seen_next = 1'b1;
                    end else if (r_bat_seen && (i_rx_byte == MOUSE_ID)) begin
                        w_idx_next   = 2'd1;
                        w_state_next = ST_SEND;
                    end else if (i_rx_byte == RSP_ERROR) begin
                        w_fault      = 1'b1;
                        w_fault_code = ERR_BAT;
                    end else begin
                        w_fault      = 1'b1;
                        w_fault_code = ERR_REPLY;
                    end
                end else if (w_expired) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    w_restart = 1'b1;
                end else if (i_rx_valid) begin
                    // Hot-plug is a BAT pair: AA immediately followed by 00
                    if (r_hp_seen && (i_rx_byte == MOUSE_ID)) begin
                        w_state_next    = ST_SEND;
                        w_idx_next      = 2'd0;
                        w_attempts_next = 3'd1;
                    end
                    w_hp_seen_next = (i_rx_byte == RSP_BAT_OK);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_restart) begin
            w_state_next    = ST_SEND;
            w_idx_next      = 2'd0;
            w_attempts_next = 3'd1;
            w_err_code_next = ERR_NONE;
        end

        // A fault restarts the whole sequence from FF until attempts run out
        if (w_fault) begin
            w_err_code_next = w_fault_code;
            if (r_attempts < 3'(MAX_RETRIES)) begin
                w_attempts_next = r_attempts + 3'd1;
                w_idx_next      = 2'd0;
                w_state_next    = ST_SEND;
            end else begin
                w_state_next = ST_FAIL;
            end
        end
    end

    // Registered outputs decoded from the upcoming state
    always_ff @(posedge i_clock_50 or posedge i_reset) begin
        if (i_reset) begin
            r_tx_valid <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_tx_valid <= (w_state_next == ST_SEND);
            if (w_state_next == ST_SEND) begin
                r_tx_byte <= step_cmd(w_idx_next);
            end
            r_busy  <= (w_state_next == ST_SEND) || (w_state_next == ST_WAIT_ACK) ||
                       (w_state_next == ST_WAIT_BAT);
            r_ready <= (w_state_next == ST_DONE);
            r_error <= (w_state_next == ST_FAIL);
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_byte  = r_tx_byte;
    assign o_busy     = r_busy;
    assign o_ready    = r_ready;
    assign o_error    = r_error;
    assign o_err_code = r_err_code;
    assign o_attempts = r_attempts;

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Directed bench for ps2_mouse_init_sequencer with a reply-script reference model.
module tb_ps2_mouse_init_sequencer;

    localparam int         ACK_T = 100;
    localparam int         BAT_T = 300;
    localparam int         MAX_R = 3;
    localparam logic [7:0] RATE  = 8'd100;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic       tx_ready = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte  = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_valid, busy, ready, error;
    logic [2:0] err_code, attempts;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    logic [7:0] txq[$];
    int         txt[$];

    ps2_mouse_init_sequencer #(
        .ACK_TIMEOUT(ACK_T),
        .BAT_TIMEOUT(BAT_T),
        .MAX_RETRIES(MAX_R),
        .SAMPLE_RATE(RATE)
    ) dut (
        .i_clock_50(clk),
        .i_reset   (rst),
        .i_start   (start),
        .o_tx_byte (tx_byte),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .i_rx_byte (rx_byte),
        .i_rx_valid(rx_valid),
        .o_busy    (busy),
        .o_ready   (ready),
        .o_error   (error),
        .o_err_code(err_code),
        .o_attempts(attempts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: a script of expected replies ----------------
    typedef enum int {P_IDLE, P_SEND, P_LISTEN, P_DONE, P_FAIL} phase_t;
    phase_t m_phase = P_IDLE;
    int     m_step  = 0;
    int     m_pos   = 0;
    int     m_wait  = 0;
    int     m_att   = 0;
    int     m_code  = 0;
    bit     m_hp    = 1'b0;

    function automatic logic [7:0] cmd_of(input int s);
        case (s)
            0:       return 8'hFF;
            1:       return 8'hF3;
            2:       return RATE;
            default: return 8'hF4;
        endcase
    endfunction

    // Bytes the mouse owes after command s: reset owes FA AA 00, others FA
    function automatic logic [7:0] need_byte(input int s, input int p);
        if (s == 0 && p == 1) return 8'hAA;
        if (s == 0 && p == 2) return 8'h00;
        return 8'hFA;
    endfunction

    function automatic int need_len(input int s);
        return (s == 0) ? 3 : 1;
    endfunction

    task automatic model_fault(input int c);
        m_code <= c;
        if (m_att < MAX_R) begin
            m_att   <= m_att + 1;
            m_step  <= 0;
            m_phase <= P_SEND;
        end else begin
            m_phase <= P_FAIL;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= P_IDLE; m_step <= 0; m_pos <= 0; m_wait <= 0;
            m_att <= 0; m_code <= 0; m_hp <= 1'b0;
        end else begin
            case (m_phase)
                P_IDLE, P_FAIL: begin
                    if (start) begin
                        m_phase <= P_SEND; m_step <= 0; m_att <= 1; m_code <= 0;
                    end
                end
                P_SEND: begin
                    if (tx_ready) begin
                        m_phase <= P_LISTEN; m_pos <= 0; m_wait <= 0;
                    end
                end
                P_LISTEN: begin
                    if (rx_valid) begin
                        if (rx_byte == need_byte(m_step, m_pos)) begin
                            if (m_pos + 1 == need_len(m_step)) begin
                                if (m_step == 3) begin
                                    m_phase <= P_DONE; m_hp <= 1'b0;
                                end else begin
                                    m_step <= m_step + 1; m_phase <= P_SEND;
                                end
                            end else begin
                                m_pos  <= m_pos + 1;
                                m_wait <= (m_pos == 0) ? 0 : m_wait + 1;
                            end
                        end else if (m_pos == 0 && rx_byte == 8'hFE) begin
                            m_phase <= P_SEND;
                        end else begin
                            model_fault((m_pos > 0 && rx_byte == 8'hFC) ? 3 : 2);
                        end
                    end else if (m_wait >= ((m_pos == 0) ? ACK_T : BAT_T)) begin
                        model_fault(1);
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                P_DONE: begin
                    if (start) begin
                        m_phase <= P_SEND; m_step <= 0; m_att <= 1; m_code <= 0;
                    end else if (rx_valid) begin
                        if (m_hp && rx_byte == 8'h00) begin
                            m_phase <= P_SEND; m_step <= 0; m_att <= 1;
                        end
                        m_hp <= (rx_byte == 8'hAA);
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("outputs",
                {22'd0, tx_valid, busy, ready, error, err_code, attempts},
                {22'd0, (m_phase == P_SEND), (m_phase == P_SEND || m_phase == P_LISTEN),
                 (m_phase == P_DONE), (m_phase == P_FAIL), 3'(m_code), 3'(m_att)});
            if (m_phase == P_SEND) chk("tx_byte", {24'd0, tx_byte}, {24'd0, cmd_of(m_step)});
        end
    end

    // Transmit handshake log
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (!rst && tx_valid && tx_ready) begin
            txq.push_back(tx_byte);
            txt.push_back(cycle);
            $display("[%0d] tx %02h", cycle, tx_byte);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        $display("[%0d] rx %02h", cycle, b);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Wait (bounded) for a command, check it, then step past the handshake edge
    task automatic wait_tx(input logic [7:0] exp, input string name);
        int n;
        n = 0;
        while (!tx_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) begin
            total++;
            bad++;
            $display("FAIL %s: no tx_valid within bound, want %02h", name, exp);
        end else begin
            chk(name, {24'd0, tx_byte}, {24'd0, exp});
        end
        @(negedge clk);
    endtask

    task automatic full_sequence(input bit late_f3);
        wait_tx(8'hFF, "seq_ff");
        rx(8'hFA); rx(8'hAA); rx(8'h00);
        wait_tx(8'hF3, "seq_f3");
        if (late_f3) cyc(ACK_T);   // reply lands exactly on the expiry cycle
        rx(8'hFA);
        wait_tx(8'h64, "seq_rate");
        rx(8'hFA);
        wait_tx(8'hF4, "seq_f4");
        rx(8'hFA);
    endtask

    function automatic int count_since(input int mark, input logic [7:0] b);
        int c;
        c = 0;
        for (int i = mark; i < txq.size(); i++) if (txq[i] == b) c++;
        return c;
    endfunction

    initial begin
        int mark;
        int n;
        // Reset state
        cyc(3);
        chk("reset_state", {14'd0, tx_valid, tx_byte, busy, ready, error, err_code, attempts}, 32'd0);
        rst = 1'b0;
        cyc(2);

        // 1: normal bring-up, tx_ready held off, a start while busy
        mark = txq.size();
        tx_ready = 1'b0;
        pulse_start;
        cyc(4);
        chk("t1_hold_valid", {31'd0, tx_valid}, 1);
        chk("t1_hold_byte", {24'd0, tx_byte}, 32'hFF);
        tx_ready = 1'b1;
        wait_tx(8'hFF, "t1_ff");
        pulse_start;               // busy: must be ignored
        rx(8'hFA); rx(8'hAA); rx(8'h00);
        wait_tx(8'hF3, "t1_f3"); rx(8'hFA);
        wait_tx(8'h64, "t1_rate"); rx(8'hFA);
        wait_tx(8'hF4, "t1_f4"); rx(8'hFA);
        chk("t1_ready", {31'd0, ready}, 1);
        chk("t1_attempts", {29'd0, attempts}, 1);
        chk("t1_err_code", {29'd0, err_code}, 0);
        chk("t1_tx_count", txq.size() - mark, 4);
        chk("t1_tx_order", {txq[mark], txq[mark+1], txq[mark+2], txq[mark+3]}, 32'hFFF364F4);

        // 2: FE to F3 causes exactly one re-send
        mark = txq.size();
        pulse_start;
        wait_tx(8'hFF, "t2_ff"); rx(8'hFA); rx(8'hAA); rx(8'h00);
        wait_tx(8'hF3, "t2_f3"); rx(8'hFE);
        wait_tx(8'hF3, "t2_f3_again"); rx(8'hFA);
        wait_tx(8'h64, "t2_rate"); rx(8'hFA);
        wait_tx(8'hF4, "t2_f4"); rx(8'hFA);
        chk("t2_ready", {31'd0, ready}, 1);
        chk("t2_attempts", {29'd0, attempts}, 1);
        chk("t2_f3_count", count_since(mark, 8'hF3), 2);

        // 4: hot-plug in DONE; a broken pair is not a hot-plug
        rx(8'hAA); rx(8'h08); rx(8'h00);
        cyc(2);
        chk("t4_no_hotplug", {31'd0, ready}, 1);
        rx(8'hAA); rx(8'h00);
        chk("t4_ready_drop", {30'd0, ready, busy}, 32'b01);
        full_sequence(1'b0);
        chk("t4_ready_back", {31'd0, ready}, 1);

        // 5: FC to FF -> code 2; FC in BAT wait -> code 3; then complete
        pulse_start;
        wait_tx(8'hFF, "t5_ff1"); rx(8'hFC);
        chk("t5_code2", {26'd0, err_code, attempts}, {26'd0, 3'd2, 3'd2});
        wait_tx(8'hFF, "t5_ff2"); rx(8'hFA); rx(8'hFC);
        chk("t5_code3", {26'd0, err_code, attempts}, {26'd0, 3'd3, 3'd3});
        full_sequence(1'b0);
        chk("t5_ready", {31'd0, ready}, 1);

        // 3: silence -> three timeouts ~ACK_T apart, then FAIL
        mark = txq.size();
        pulse_start;
        n = 0;
        while (!error && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t3_error", {31'd0, error}, 1);
        chk("t3_state", {28'd0, busy, err_code}, {28'd0, 1'b0, 3'd1});
        chk("t3_attempts", {29'd0, attempts}, 3);
        chk("t3_ff_count", count_since(mark, 8'hFF), 3);
        if (txq.size() - mark == 3) begin
            chk("t3_gap1", txt[mark+1] - txt[mark], ACK_T + 2);
            chk("t3_gap2", txt[mark+2] - txt[mark+1], ACK_T + 2);
        end

        // 6: reset while tx_valid is held drops it without a clock edge
        tx_ready = 1'b0;
        pulse_start;
        chk("t6_valid_before", {31'd0, tx_valid}, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_drop", {30'd0, tx_valid, busy}, 0);
        cyc(2);
        rst = 1'b0;
        tx_ready = 1'b1;
        cyc(1);
        mark = txq.size();
        pulse_start;
        full_sequence(1'b1);
        chk("t6_ready", {31'd0, ready}, 1);
        chk("t6_attempts", {26'd0, err_code, attempts}, {26'd0, 3'd0, 3'd1});
        chk("t6_tx_count", txq.size() - mark, 4);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
